mem_replay_select: RTL

- Consumer end of the memory replay path; sits between the memory issue queue, the replay buffer and the memory pipe's register-read stage.
- Normally passes issue-queue picks into the memory pipe.
- On a failed speculative load wakeup it freezes the replay buffer, waits for the miss to resolve, then re-issues the two buffered dependents from the replay stream before handing the pipe back to the issue queue.

---
 rtl/mem_replay_select.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_replay_select.sv
// Memory-pipe issue select: passes issue-queue picks, and on a failed load wakeup freezes,
// waits for the miss, then re-issues the replay buffer. Perf counters exist only under MEM_REPLAY_PERF_CNT_EN.
package mem_replay_pkg;
    localparam int ROB_TAG_W = 6;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] rob_tag;
    } branch_flush_t;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [5:0]           prd;
        logic                 is_load;
        logic [11:0]          imm;
    } mem_dispatch_pack_t;

    // The kill broadcast names the squashed ROB entry directly.
    function automatic logic IsBrROBKill(input branch_flush_t f, input logic [ROB_TAG_W-1:0] tag);
        return f.valid && (f.rob_tag == tag);
    endfunction
endpackage

module mem_replay_select
    import mem_replay_pkg::*;
#(
    parameter int MIN_HOLD_CYCLES = 2,
    parameter int REPLAY_SLOTS    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  branch_flush_t      recovery_flush_BCAST,
    input  logic               recovery_stall,
    input  logic               replay_muldiv_stall,
    input  logic               load_wake_up_predict_failed,
    input  logic               miss_resolved,
    input  logic               iq_issue_valid,
    input  mem_dispatch_pack_t iq_issue_pack,
    output logic               iq_issue_ready,
    input  logic               replay_valid,
    input  mem_dispatch_pack_t replay_pack,
    output logic               load_wake_up_failed_stall,
    output logic               mem_issue_valid,
    output mem_dispatch_pack_t mem_issue_pack,
    output logic               replay_active,
    output logic [31:0]        perf_replay_events,
    output logic [31:0]        perf_hold_cycles
);
    localparam int CNT_W  = 4;
    localparam int SLOT_W = (REPLAY_SLOTS > 1) ? $clog2(REPLAY_SLOTS) : 1;
    localparam logic [CNT_W-1:0]  HOLD_MIN  = CNT_W'(MIN_HOLD_CYCLES);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REPLAY_SLOTS - 1);

    typedef enum logic [1:0] {S_NORMAL, S_HOLD, S_REPLAY} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SLOT_W-1:0]  slot_cnt_q;
    logic               miss_seen_q;
    logic               pf_pend_q;
    logic               freeze_q;
    logic               active_q;
    logic               out_valid_q;
    mem_dispatch_pack_t out_pack_q;

    logic stall, pf_eff, miss_ok, enter_hold;
    logic iq_kill, rp_kill, out_kill;

    assign stall      = recovery_stall | replay_muldiv_stall;
    // A failure seen while stalled is replayed here on the first free cycle.
    assign pf_eff     = load_wake_up_predict_failed | pf_pend_q;
    assign miss_ok    = miss_seen_q | miss_resolved;
    assign hold_cnt_d = (hold_cnt_q >= HOLD_MIN) ? hold_cnt_q : hold_cnt_q + 1'b1;
    assign enter_hold = !stall && pf_eff && (state_q != S_HOLD);

    assign iq_kill  = IsBrROBKill(recovery_flush_BCAST, iq_issue_pack.rob_tag);
    assign rp_kill  = IsBrROBKill(recovery_flush_BCAST, replay_pack.rob_tag);
    assign out_kill = IsBrROBKill(recovery_flush_BCAST, out_pack_q.rob_tag);

    assign iq_issue_ready            = (state_q == S_NORMAL) && !stall && !pf_eff;
    assign load_wake_up_failed_stall = freeze_q;
    assign replay_active             = active_q;
    assign mem_issue_valid           = out_valid_q;
    assign mem_issue_pack            = out_pack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_NORMAL;
            hold_cnt_q  <= '0;
            slot_cnt_q  <= '0;
            miss_seen_q <= 1'b0;
            pf_pend_q   <= 1'b0;
            freeze_q    <= 1'b0;
            active_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_pack_q  <= '0;
        end else if (stall) begin
            if (load_wake_up_predict_failed && state_q != S_HOLD)
                pf_pend_q <= 1'b1;
            if (miss_resolved && state_q == S_HOLD)
                miss_seen_q <= 1'b1;
            if (out_kill)
                out_valid_q <= 1'b0;
        end else begin
            pf_pend_q <= 1'b0;
            case (state_q)
                S_NORMAL: begin
                    if (pf_eff) begin
                        state_q     <= S_HOLD;
                        hold_cnt_q  <= '0;
                        miss_seen_q <= 1'b0;
                        freeze_q    <= 1'b1;
                        active_q    <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else begin
                        out_valid_q <= iq_issue_valid && !iq_kill;
                        out_pack_q  <= iq_issue_pack;
                    end
                end
                S_HOLD: begin
                    out_valid_q <= 1'b0;
                    hold_cnt_q  <= hold_cnt_d;
                    if (hold_cnt_d >= HOLD_MIN && miss_ok) begin
                        state_q     <= S_REPLAY;
                        slot_cnt_q  <= '0;
                        miss_seen_q <= 1'b0;
                        freeze_q    <= 1'b0;
                    end else if (miss_resolved) begin
                        miss_seen_q <= 1'b1;
                    end
                end
                S_REPLAY: begin
                    if (pf_eff) begin
                        state_q     <= S_HOLD;
                        hold_cnt_q  <= '0;
                        slot_cnt_q  <= '0;
                        miss_seen_q <= 1'b0;
                        freeze_q    <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else begin
                        // Dead slots still count toward the episode length.
                        out_valid_q <= replay_valid && !rp_kill;
                        out_pack_q  <= replay_pack;
                        if (slot_cnt_q == SLOT_LAST) begin
                            state_q    <= S_NORMAL;
                            slot_cnt_q <= '0;
                            active_q   <= 1'b0;
                        end else begin
                            slot_cnt_q <= slot_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= S_NORMAL;
                    freeze_q <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_REPLAY_PERF_CNT_EN
    logic [31:0] perf_events_q, perf_hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_events_q <= '0;
            perf_hold_q   <= '0;
        end else begin
            if (enter_hold)
                perf_events_q <= perf_events_q + 32'd1;
            if (state_q == S_HOLD)
                perf_hold_q <= perf_hold_q + 32'd1;
        end
    end

    assign perf_replay_events = perf_events_q;
    assign perf_hold_cycles   = perf_hold_q;
`else
    logic unused_perf;
    assign unused_perf        = enter_hold;
    assign perf_replay_events = '0;
    assign perf_hold_cycles   = '0;
`endif

endmodule
